mfcc_lift_sequencer: RTL and testbench
======================================

Name: mfcc_lift_sequencer

Overview:
- Frame-level controller in front of the cepstral lifter stage.
- The lifter indexes its coefficient table by run length and resets its index whenever input valid drops, so every frame must reach it as one gap-free burst of NUM_COEF words.
- This block collects DCT-II outputs (arriving with arbitrary gaps) into a frame buffer and issues each frame as one contiguous burst.
- It counts the lifted results returned, flags frame completion and errors, and back-pressures upstream while a frame is in flight.

Parameters:
- NUM_COEF, 13: coefficients per frame; range 2..16.
- DATA_W, 32: IEEE-754 single-precision word width.
- TIMEOUT, 64: cycles allowed between burst end and the last returned result.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- s_tvalid  in  1  DCT-II coefficient valid
- s_tdata  in  DATA_W  DCT-II coefficient
- s_tready  out  1  block can accept a coefficient
- lift_tvalid  out  1  drives lifter tvalid_dct2_feat
- lift_tdata  out  DATA_W  drives lifter dct2_feat
- res_tvalid  in  1  lifter tvalid_mfcc_feat
- res_tdata  in  DATA_W  lifter mfcc_feat
- m_tvalid  out  1  forwarded MFCC valid
- m_tdata  out  DATA_W  forwarded MFCC word
- m_tlast  out  1  marks the last word of a frame
- frame_done  out  1  one-cycle pulse when a frame completes
- err_overrun  out  1  sticky: write attempted while s_tready=0
- err_timeout  out  1  sticky: results missing after TIMEOUT

Behaviour:
- Reset: rst=0 sampled on a clk edge clears all state.
  - Outputs go to: s_tready=0 for one cycle, then 1; lift_tvalid=0; lift_tdata=0; m_tvalid=0; m_tdata=0; m_tlast=0; frame_done=0; err_*=0.
  - FSM goes to FILL; wr_cnt=rd_cnt=res_cnt=0.
  - Buffer contents are don't-care.
  - Reset mid-burst drops lift_tvalid on the next cycle, which resets the lifter index. Results arriving after reset are ignored until the next BURST.
- FSM states: FILL, BURST, DRAIN.
- FILL:
  - s_tready=1.
  - On s_tvalid: buf[wr_cnt]<=s_tdata and wr_cnt increments.
  - When the write of index NUM_COEF-1 is accepted: wr_cnt<=0, s_tready<=0 registered, next state BURST.
- BURST:
  - lift_tvalid=1 for exactly NUM_COEF consecutive cycles, with lift_tdata=buf[rd_cnt] registered and rd_cnt going 0..NUM_COEF-1.
  - First lift_tvalid appears on the cycle after the FILL to BURST transition. Gaps are never allowed.
  - After the last word: lift_tvalid<=0, lift_tdata<=0, timeout counter cleared, next state DRAIN.
- DRAIN:
  - Waits for remaining results. The timeout counter increments each cycle.
  - When res_cnt reaches NUM_COEF: frame_done pulses, res_cnt<=0, next state FILL, s_tready<=1.
  - If the counter reaches TIMEOUT first: err_timeout<=1, res_cnt<=0, next state FILL.
- Result forwarding (any state):
  - Each res_tvalid is counted in res_cnt only while in BURST or DRAIN.
  - Each counted result is registered to m_tvalid/m_tdata with 1-cycle latency.
  - m_tlast=1 with the word where res_cnt==NUM_COEF-1.
  - Results in FILL are discarded and not forwarded.
- Overrun: s_tvalid=1 while s_tready=0 sets err_overrun and the word is dropped. Errors clear only on reset.
- Simultaneous events:
  - A result arriving on the BURST to DRAIN edge is counted.
  - frame_done and the first FILL accept can share the next cycle.
- Throughput bound: NUM_COEF fill + NUM_COEF burst + lifter latency per frame. The block does not depend on the lifter's internal latency.

Optional Feature:
- Macro: MFCC_LIFT_SEQ_FRAME_CNT_EN.
- Defined: adds output port frame_cnt, 16-bit.
  - Reset 0.
  - Increments on each frame_done and wraps at 0xFFFF to 0.
  - Not incremented on a timeout abort.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package mfcc_pkg holds:
  - the FSM state encoding (FILL=2'd0, BURST=2'd1, DRAIN=2'd2);
  - the default NUM_COEF=13 and DATA_W=32;
  - the counter-width function clog2(NUM_COEF).
- One sub-module, mfcc_frame_buf: NUM_COEF x DATA_W register array with a synchronous write port and a registered read port. The sequencer owns all the counters.

Test Plan:
- Contiguous fill: write 13 words 0x3f800000..(+1 each) back to back, with a lifter model of latency 5 → lift_tvalid high exactly 13 consecutive cycles in write order; m_tlast on the 13th result; one frame_done.
- Gapped input: 13 words with 1–7 random idle cycles between them → the burst to the lifter is still gap-free; output data matches the lifter model.
- Overrun: drive s_tvalid during BURST → word dropped, err_overrun=1 and held; the next frame completes normally.
- Timeout: lifter model returns only 12 results → err_timeout=1 at 64 cycles after burst end; FSM back in FILL with s_tready=1; no frame_done.
- Mid-burst reset: assert rst=0 at burst word 6 → next cycle lift_tvalid=0 and all outputs at reset values; a fresh 13-word frame then completes correctly.
- Frame counter (with MFCC_LIFT_SEQ_FRAME_CNT_EN defined): 3 frames → frame_cnt=3; preload near 0xFFFF and complete 2 frames → wraps to 0x0000.

Source files
------------

// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared state encoding, defaults and width helper for the MFCC lifter sequencer
package mfcc_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    localparam int DEF_NUM_COEF = 13;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_TIMEOUT  = 64;

    // Ceil(log2(value)) with a floor of one bit so tiny counters stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mfcc_frame_buf.sv
// rtl/mfcc_frame_buf.sv - NUM_COEF x DATA_W frame store, synchronous write, registered read
module mfcc_frame_buf
    import mfcc_pkg::*;
#(
    parameter int NUM_COEF = DEF_NUM_COEF,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AW       = clog2(NUM_COEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_COEF];

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register returns to zero whenever no read is issued, so it can drive the lifter data bus directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/mfcc_lift_sequencer.sv
// rtl/mfcc_lift_sequencer.sv - frame collector and gap-free burst issuer for the cepstral lifter; MFCC_LIFT_SEQ_FRAME_CNT_EN adds frame_cnt
module mfcc_lift_sequencer
    import mfcc_pkg::*;
#(
    parameter int NUM_COEF = DEF_NUM_COEF,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              s_tready,
    output logic              lift_tvalid,
    output logic [DATA_W-1:0] lift_tdata,
    input  logic              res_tvalid,
    input  logic [DATA_W-1:0] res_tdata,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              frame_done,
    output logic              err_overrun,
`ifdef MFCC_LIFT_SEQ_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic              err_timeout
);

    localparam int CW = clog2(NUM_COEF);
    localparam int RW = clog2(NUM_COEF + 1);
    localparam int TW = clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_COEF - 1);
    localparam logic [RW-1:0] RES_FULL = RW'(NUM_COEF);
    localparam logic [RW-1:0] RES_LAST = RW'(NUM_COEF - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic [RW-1:0] res_cnt_q;
    logic [TW-1:0] to_cnt_q;

    logic wr_en;
    logic rd_en;
    logic res_take;
    logic frame_end;
    logic timeout_hit;

    mfcc_frame_buf #(
        .NUM_COEF (NUM_COEF),
        .DATA_W   (DATA_W),
        .AW       (CW)
    ) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt_q),
        .wr_data (s_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt_q),
        .rd_data (lift_tdata)
    );

    // Next state and per-cycle strobes; results only count once a burst has started.
    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        frame_end   = 1'b0;
        timeout_hit = 1'b0;
        res_take    = res_tvalid && (state_q != FILL) && (res_cnt_q != RES_FULL);
        case (state_q)
            FILL: begin
                wr_en = s_tvalid && s_tready;
                if (wr_en && (wr_cnt_q == LAST_IDX)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                rd_en = 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (res_cnt_q == RES_FULL) begin
                    frame_end = 1'b1;
                    state_d   = FILL;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, counters, result forwarding and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            res_cnt_q   <= '0;
            to_cnt_q    <= '0;
            s_tready    <= 1'b0;
            lift_tvalid <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_tready    <= (state_d == FILL);
            lift_tvalid <= rd_en;
            frame_done  <= frame_end;

            if (wr_en) begin
                wr_cnt_q <= (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + CW'(1);
            end
            if (rd_en) begin
                rd_cnt_q <= (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + CW'(1);
            end

            // Timeout window opens when the last burst word is issued.
            if (state_q == BURST) begin
                to_cnt_q <= '0;
            end else if (state_q == DRAIN) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            if (frame_end || timeout_hit) begin
                res_cnt_q <= '0;
            end else if (res_take) begin
                res_cnt_q <= res_cnt_q + RW'(1);
            end

            m_tvalid <= res_take;
            m_tdata  <= res_take ? res_tdata : '0;
            m_tlast  <= res_take && (res_cnt_q == RES_LAST);

            if (s_tvalid && !s_tready) begin
                err_overrun <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef MFCC_LIFT_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter; timeout aborts are not counted and it wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mfcc_lift_sequencer.sv
// tb/tb_mfcc_lift_sequencer.sv - scoreboard bench for mfcc_lift_sequencer; MFCC_LIFT_SEQ_FRAME_CNT_EN enables frame_cnt checks
module tb_mfcc_lift_sequencer;

    localparam int NC  = 13;
    localparam int DW  = 32;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tready;
    logic          lift_tvalid;
    logic [DW-1:0] lift_tdata;
    logic          res_tvalid;
    logic [DW-1:0] res_tdata;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          frame_done;
    logic          err_overrun;
    logic          err_timeout;
`ifdef MFCC_LIFT_SEQ_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    always #5 clk = ~clk;

    mfcc_lift_sequencer #(
        .NUM_COEF (NC),
        .DATA_W   (DW),
        .TIMEOUT  (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tready    (s_tready),
        .lift_tvalid (lift_tvalid),
        .lift_tdata  (lift_tdata),
        .res_tvalid  (res_tvalid),
        .res_tdata   (res_tdata),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .frame_done  (frame_done),
        .err_overrun (err_overrun),
`ifdef MFCC_LIFT_SEQ_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int run_len = 0;
    int ret_limit = NC;

    logic [32:0] exp_m [$];
    logic [31:0] lift_exp [$];
    int          run_exp [$];
    logic [32:0] sb_e;

    int gaps [12] = '{3, 1, 7, 2, 5, 4, 6, 1, 2, 7, 3, 5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lifter model: adds its run-length index to each word, index restarts when tvalid drops.
    logic [DW-1:0] pipe_d [LAT] = '{default: '0};
    logic          pipe_v [LAT] = '{default: 1'b0};
    int            run_idx = 0;
    int            ret_cnt = 0;
    always @(negedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        if (lift_tvalid) begin
            if (run_idx == 0) ret_cnt = 0;
            pipe_v[0] = 1'b1;
            pipe_d[0] = lift_tdata + 32'(run_idx);
            run_idx++;
        end else begin
            pipe_v[0] = 1'b0;
            pipe_d[0] = '0;
            run_idx   = 0;
        end
        if (pipe_v[LAT-1] && (ret_cnt < ret_limit)) begin
            res_tvalid = 1'b1;
            res_tdata  = pipe_d[LAT-1];
            ret_cnt++;
        end else begin
            res_tvalid = 1'b0;
            res_tdata  = '0;
        end
    end

    // Scoreboard monitor for forwarded results.
    always @(negedge clk) begin
        if (m_tvalid) begin
            if (exp_m.size() == 0) begin
                check("m_unexpected_word", 32'(exp_m.size()), 1);
            end else begin
                sb_e = exp_m.pop_front();
                check("m_tdata", m_tdata, sb_e[31:0]);
                check("m_tlast", 32'(m_tlast), 32'(sb_e[32]));
            end
        end
    end

    // Burst monitor: word order on the lifter bus and gap-free run length.
    always @(negedge clk) begin
        if (lift_tvalid) begin
            run_len++;
            if (lift_exp.size() == 0) begin
                check("lift_unexpected_word", 32'(lift_exp.size()), 1);
            end else begin
                check("lift_tdata", lift_tdata, lift_exp.pop_front());
            end
        end else if (run_len != 0) begin
            if (run_exp.size() == 0) begin
                check("lift_unexpected_run", 32'(run_exp.size()), 1);
            end else begin
                check("lift_run_len", 32'(run_len), 32'(run_exp.pop_front()));
            end
            run_len = 0;
        end
    end

    // Frame completion pulse counter.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
    end

    task automatic send_word(input logic [31:0] d);
        int guard;
        guard = 0;
        while (!s_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_tready) check("s_tready_wait", 32'(s_tready), 1);
        s_tvalid = 1'b1;
        s_tdata  = d;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int gapped, input int n_ret, input int exp_run);
        logic [31:0] w;
        for (int k = 0; k < NC; k++) begin
            w = base + 32'(k);
            lift_exp.push_back(w);
            if (k < n_ret) exp_m.push_back({(k == NC - 1), w + 32'(k)});
            send_word(w);
            if (gapped != 0 && k < NC - 1) repeat (gaps[k]) @(negedge clk);
        end
        run_exp.push_back(exp_run);
    endtask

    task automatic wait_done(input int target);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("frame_done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_lift();
        int guard;
        guard = 0;
        while (!lift_tvalid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("lift_start", 32'(lift_tvalid), 1);
    endtask

    int n;
    int last_lv;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 0);
        check("rst_lift_tvalid", 32'(lift_tvalid), 0);
        check("rst_lift_tdata", lift_tdata, 0);
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", 32'(m_tlast), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err_overrun", 32'(err_overrun), 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        rst = 1'b1;
        @(negedge clk);
        check("s_tready_after_reset", 32'(s_tready), 1);

        send_frame(32'h3f80_0000, 0, NC, NC);
        wait_done(1);

        send_frame(32'h4000_0000, 1, NC, NC);
        wait_done(2);

        send_frame(32'h4040_0000, 0, NC, NC);
        wait_lift();
        s_tvalid = 1'b1;
        s_tdata  = 32'hdead_beef;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tdata  = '0;
        check("err_overrun_set", 32'(err_overrun), 1);
        wait_done(3);

        send_frame(32'h4080_0000, 0, NC, NC);
        wait_done(4);
        check("err_overrun_held", 32'(err_overrun), 1);
        check("err_timeout_clear", 32'(err_timeout), 0);

        ret_limit = NC - 1;
        send_frame(32'h40a0_0000, 0, NC - 1, NC);
        n = 0;
        last_lv = -1;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            n++;
            if (lift_tvalid) last_lv = n;
        end
        check("err_timeout_set", 32'(err_timeout), 1);
        check("timeout_delay", 32'(n - last_lv), 64);
        check("s_tready_after_timeout", 32'(s_tready), 1);
        check("no_done_on_timeout", 32'(done_cnt), 4);
        ret_limit = NC;

        send_frame(32'h40c0_0000, 0, 2, 7);
        wait_lift();
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_lift_tvalid", 32'(lift_tvalid), 0);
        check("mid_rst_lift_tdata", lift_tdata, 0);
        check("mid_rst_s_tready", 32'(s_tready), 0);
        check("mid_rst_m_tvalid", 32'(m_tvalid), 0);
        check("mid_rst_m_tdata", m_tdata, 0);
        check("mid_rst_err_overrun", 32'(err_overrun), 0);
        check("mid_rst_err_timeout", 32'(err_timeout), 0);
        lift_exp.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s_tready_after_mid_rst", 32'(s_tready), 1);
        send_frame(32'h40e0_0000, 0, NC, NC);
        wait_done(5);

`ifdef MFCC_LIFT_SEQ_FRAME_CNT_EN
        check("frame_cnt_one", 32'(frame_cnt), 1);
        send_frame(32'h4100_0000, 0, NC, NC);
        wait_done(6);
        send_frame(32'h4110_0000, 1, NC, NC);
        wait_done(7);
        check("frame_cnt_three", 32'(frame_cnt), 3);
        force dut.frame_cnt_q = 16'hfffe;
        @(negedge clk);
        release dut.frame_cnt_q;
        send_frame(32'h4120_0000, 0, NC, NC);
        wait_done(8);
        check("frame_cnt_ffff", 32'(frame_cnt), 32'h0000_ffff);
        send_frame(32'h4130_0000, 0, NC, NC);
        wait_done(9);
        check("frame_cnt_wrap", 32'(frame_cnt), 0);
`endif

        repeat (20) @(negedge clk);
        check("m_queue_drained", 32'(exp_m.size()), 0);
        check("lift_queue_drained", 32'(lift_exp.size()), 0);
        check("run_queue_drained", 32'(run_exp.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
